// File: rtl/booth_product_accumulator.sv
// Saturating accumulator that sums a programmed burst of signed products from the
// Booth multiplier and presents the dot-product result over a valid/ready port.
module booth_product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [LEN_W-1:0]         i_len,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic signed [PROD_W-1:0] i_in_product,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic signed [ACC_W-1:0]  o_out_acc,
    output logic                     o_out_sat,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_sat;
    logic [LEN_W-1:0]          r_cnt;
    logic                      w_beat;
    logic signed [ACC_W:0]     w_sum;

    // The two top bits of the widened sum disagree exactly when it left the ACC_W range.
    function automatic logic sat_ovf(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return $signed(s[ACC_W-1:0]);
    endfunction

    assign w_beat = i_in_valid && (r_state == S_ACCUM);
    assign w_sum  = {r_acc[ACC_W-1], r_acc}
                  + {{(ACC_W+1-PROD_W){i_in_product[PROD_W-1]}}, i_in_product};

    assign o_in_ready  = (r_state == S_ACCUM);
    assign o_out_valid = (r_state == S_DONE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_out_acc   = r_acc;
    assign o_out_sat   = r_sat;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start)
                    w_state_nxt = (i_len == '0) ? S_DONE : S_ACCUM;
            end
            S_ACCUM: begin
                if (w_beat && (r_cnt == LEN_W'(1)))
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                        r_cnt <= i_len;
                    end
                end
                S_ACCUM: begin
                    // Accumulation resumes from the clamped value; the flag is sticky.
                    if (w_beat) begin
                        r_acc <= sat_clamp(w_sum);
                        r_sat <= r_sat | sat_ovf(w_sum);
                        r_cnt <= r_cnt - LEN_W'(1);
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: directed bursts plus random bursts checked
// against a plain-arithmetic saturating-sum model.
module tb_booth_product_accumulator;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 24;
    localparam int LEN_W  = 10;
    localparam longint ACC_MAX = 64'sd8388607;
    localparam longint ACC_MIN = -64'sd8388608;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic [LEN_W-1:0]         len;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [PROD_W-1:0] in_product;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_acc;
    logic                     out_sat;
    logic                     busy;

    int tests  = 0;
    int failed = 0;
    int prods [1024];

    booth_product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_len        (len),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_product (in_product),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_acc    (out_acc),
        .o_out_sat    (out_sat),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One complete burst: start, beats (with optional stalls), result hold, handshake.
    task automatic run_burst(input string name, input int n, input int min_gap,
                             input int max_gap, input int hold, input bit poke);
        longint acc = 0;
        bit     sat = 0;
        int     gaps;
        check({name, " idle_before"}, busy, 0);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
        for (int k = 0; k < n; k++) begin
            gaps = $urandom_range(min_gap, max_gap);
            for (int g = 0; g < gaps; g++) begin
                in_valid   = 1'b0;
                in_product = PROD_W'($urandom);
                tick();
                check({name, " stall_ready"}, in_ready, 1);
                check({name, " stall_acc"}, out_acc, acc);
                check({name, " stall_valid"}, out_valid, 0);
            end
            in_valid   = 1'b1;
            in_product = PROD_W'(prods[k]);
            tick();
            in_valid = 1'b0;
            acc = acc + longint'(prods[k]);
            if (acc > ACC_MAX) begin acc = ACC_MAX; sat = 1; end
            if (acc < ACC_MIN) begin acc = ACC_MIN; sat = 1; end
            check({name, " live_acc"}, out_acc, acc);
            check({name, " live_sat"}, out_sat, longint'(sat));
            if (k < n - 1)
                check({name, " early_valid"}, out_valid, 0);
        end
        check({name, " out_valid"}, out_valid, 1);
        check({name, " out_acc"}, out_acc, acc);
        check({name, " out_sat"}, out_sat, longint'(sat));
        check({name, " done_ready"}, in_ready, 0);
        check({name, " done_busy"}, busy, 1);
        for (int h = 0; h < hold; h++) begin
            start = poke;
            len   = LEN_W'(5);
            tick();
            start = 1'b0;
            check({name, " hold_valid"}, out_valid, 1);
            check({name, " hold_acc"}, out_acc, acc);
            check({name, " hold_sat"}, out_sat, longint'(sat));
        end
        out_ready = 1'b1;
        start     = poke;
        len       = LEN_W'(5);
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check({name, " after_valid"}, out_valid, 0);
        check({name, " after_busy"}, busy, 0);
        check({name, " after_ready"}, in_ready, 0);
        check({name, " idle_acc"}, out_acc, acc);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        in_valid   = 1'b0;
        in_product = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_sat", out_sat, 0);
        check("rst busy", busy, 0);
        check("rst out_acc", out_acc, 0);
        rst_n = 1'b1;
        tick();

        prods[0] = 100; prods[1] = -250; prods[2] = 32767;
        run_burst("t1_basic", 3, 0, 0, 0, 1'b0);

        run_burst("t2_len0", 0, 0, 0, 1, 1'b0);

        for (int k = 0; k < 300; k++) prods[k] = 32767;
        run_burst("t3_satpos", 300, 0, 0, 0, 1'b0);
        for (int k = 0; k < 256; k++) prods[k] = -32768;
        run_burst("t3_satneg", 256, 0, 0, 0, 1'b0);

        for (int k = 0; k < 4; k++) prods[k] = int'($urandom_range(0, 20000)) - 10000;
        run_burst("t4_gaps", 4, 1, 3, 5, 1'b1);

        start = 1'b1;
        len   = LEN_W'(4);
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_product = 16'sd1000; tick();
        in_product = 16'sd2000; tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("t5 rst in_ready", in_ready, 0);
        check("t5 rst out_valid", out_valid, 0);
        check("t5 rst out_sat", out_sat, 0);
        check("t5 rst busy", busy, 0);
        check("t5 rst out_acc", out_acc, 0);
        rst_n = 1'b1;
        tick();
        prods[0] = 5; prods[1] = 7;
        run_burst("t5_after_rst", 2, 0, 0, 0, 1'b0);

        prods[0] = -128 * -128; prods[1] = -128 * -128; prods[2] = 127 * -128;
        run_burst("t6_booth", 3, 0, 0, 0, 1'b0);

        for (int b = 0; b < 8; b++) begin
            n = $urandom_range(1, 24);
            for (int k = 0; k < n; k++)
                prods[k] = int'($urandom_range(0, 65535)) - 32768;
            run_burst("rand", n, 0, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        for (int k = 0; k < 700; k++)
            prods[k] = ($urandom_range(0, 2) != 0) ? 32767 : -32768;
        run_burst("rand_sat", 700, 0, 0, 1, 1'b0);
        for (int k = 0; k < 700; k++)
            prods[k] = ($urandom_range(0, 2) != 0) ? -32768 : 32767;
        run_burst("rand_satneg", 700, 0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
